// File: rtl/hex_scroll_ctrl.sv
// Two-digit scrolling hex display controller.
// Shows a sliding HEX1/HEX0 window over a loaded nibble buffer for LOOPS revolutions.
module hex_scroll_ctrl #(
    parameter int DIV   = 50000000,
    parameter int NDIG  = 4,
    parameter int LOOPS = 2
) (
    input  logic                    CLOCK_50,
    input  logic                    RST,
    input  logic                    LOAD,
    input  logic [4*NDIG-1:0]       DATA,
    input  logic                    PAUSE,
    output logic                    READY,
    output logic                    DONE,
    output logic [$clog2(NDIG)-1:0] POS,
    output logic [0:6]              HEX1,
    output logic [0:6]              HEX0
);
    localparam int PW  = $clog2(NDIG);
    localparam int PRW = $clog2(DIV);
    localparam int LW  = $clog2(LOOPS + 1);
    localparam logic [0:6] BLANK = 7'b1111111;

    typedef enum logic {IDLE, SHOW} state_t;

    state_t            state_q, state_d;
    logic [4*NDIG-1:0] buf_q, buf_d;
    logic [PW-1:0]     pos_q, pos_d, pos_nx;
    logic [PRW-1:0]    pre_q, pre_d;
    logic [LW-1:0]     loop_q, loop_d;
    logic              done_q, done_d;

    function automatic logic [0:6] seg(input logic [3:0] v);
        unique case (v)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
    endfunction

    // Nibble 0 sits in the top bits, so shift the wanted one up to the MSBs.
    function automatic logic [3:0] nib(input logic [4*NDIG-1:0] b,
                                       input logic [PW-1:0] i);
        logic [4*NDIG-1:0] sh;
        sh = b << {i, 2'b00};
        return sh[4*NDIG-1 -: 4];
    endfunction

    assign pos_nx = (pos_q == PW'(NDIG - 1)) ? '0 : pos_q + PW'(1);

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state_q <= IDLE;
            buf_q   <= '0;
            pos_q   <= '0;
            pre_q   <= '0;
            loop_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            pos_q   <= pos_d;
            pre_q   <= pre_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        pos_d   = pos_q;
        pre_d   = pre_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (LOAD) begin
                    buf_d   = DATA;
                    pos_d   = '0;
                    pre_d   = '0;
                    loop_d  = '0;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (!PAUSE) begin
                    if (pre_q == PRW'(DIV - 1)) begin
                        pre_d = '0;
                        pos_d = pos_nx;
                        if (pos_q == PW'(NDIG - 1)) begin
                            if (loop_q == LW'(LOOPS - 1)) begin
                                state_d = IDLE;
                                pos_d   = '0;
                                loop_d  = '0;
                                done_d  = 1'b1;
                            end else begin
                                loop_d = loop_q + LW'(1);
                            end
                        end
                    end else begin
                        pre_d = pre_q + PRW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign READY = (state_q == IDLE);
    assign DONE  = done_q;
    assign POS   = pos_q;
    assign HEX1  = READY ? BLANK : seg(nib(buf_q, pos_q));
    assign HEX0  = READY ? BLANK : seg(nib(buf_q, pos_nx));

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl with DIV=4, NDIG=4, LOOPS=2.
// Expected windows for 16'h1A2F are hand-tabulated.
module tb_hex_scroll_ctrl;
    logic        CLOCK_50 = 1'b0;
    logic        RST = 1'b1;
    logic        LOAD = 1'b0;
    logic [15:0] DATA = '0;
    logic        PAUSE = 1'b0;
    logic        READY;
    logic        DONE;
    logic [1:0]  POS;
    logic [0:6]  HEX1;
    logic [0:6]  HEX0;

    int tests = 0;
    int fails = 0;

    localparam logic [6:0] BLK = 7'b1111111;
    logic [6:0] hx1 [4] = '{7'b1001111, 7'b0001000, 7'b0010010, 7'b0111000};
    logic [6:0] hx0 [4] = '{7'b0001000, 7'b0010010, 7'b0111000, 7'b1001111};

    hex_scroll_ctrl #(.DIV(4), .NDIG(4), .LOOPS(2)) dut (
        .CLOCK_50(CLOCK_50),
        .RST(RST),
        .LOAD(LOAD),
        .DATA(DATA),
        .PAUSE(PAUSE),
        .READY(READY),
        .DONE(DONE),
        .POS(POS),
        .HEX1(HEX1),
        .HEX0(HEX0)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(READY), 32'd1);
        chk({tag, "_pos"}, 32'(POS), 32'd0);
        chk({tag, "_hex1"}, 32'(HEX1), 32'(BLK));
        chk({tag, "_hex0"}, 32'(HEX0), 32'(BLK));
    endtask

    task automatic chk_win(input string tag, input int p);
        chk({tag, "_pos"}, 32'(POS), 32'(p));
        chk({tag, "_hex1"}, 32'(HEX1), 32'(hx1[p]));
        chk({tag, "_hex0"}, 32'(HEX0), 32'(hx0[p]));
        chk({tag, "_ready"}, 32'(READY), 32'd0);
        chk({tag, "_done"}, 32'(DONE), 32'd0);
    endtask

    initial begin
        int ee;
        // reset and idle
        step();
        step();
        RST = 1'b0;
        chk_idle("rst");
        chk("rst_done", 32'(DONE), 32'd0);
        step();
        chk_idle("idle");

        // load, scroll, mid-scroll LOAD ignored, completion
        LOAD = 1'b1;
        DATA = 16'h1A2F;
        step();
        LOAD = 1'b1;
        DATA = 16'h0000;
        chk_win("win0", 0);
        for (int e = 1; e <= 31; e++) begin
            step();
            if (e == 20) LOAD = 1'b0;
            chk_win("run", (e / 4) % 4);
        end
        step();
        chk("done_pulse", 32'(DONE), 32'd1);
        chk_idle("done");
        step();
        chk("done_clear", 32'(DONE), 32'd0);
        chk_idle("after");

        // pause at prescaler=2 for 10 cycles
        LOAD = 1'b1;
        DATA = 16'h1A2F;
        step();
        LOAD = 1'b0;
        for (int e = 1; e <= 41; e++) begin
            step();
            if (e == 2) PAUSE = 1'b1;
            if (e == 12) PAUSE = 1'b0;
            ee = (e <= 2) ? e : (e <= 12) ? 2 : e - 10;
            chk_win("pause", (ee / 4) % 4);
        end
        step();
        chk("pdone_pulse", 32'(DONE), 32'd1);
        chk_idle("pdone");

        // LOAD and PAUSE together in idle
        step();
        LOAD = 1'b1;
        PAUSE = 1'b1;
        step();
        LOAD = 1'b0;
        for (int e = 0; e < 6; e++) begin
            step();
            chk_win("lp_hold", 0);
        end
        PAUSE = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk_win("lp_run", e / 4);
        end
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_idle("lp_rst");

        // reset mid-scroll at POS=2
        LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        for (int e = 1; e <= 8; e++) step();
        chk_win("pre_rst", 2);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_idle("mid_rst");
        chk("mid_rst_done", 32'(DONE), 32'd0);
        for (int e = 0; e < 40; e++) begin
            step();
            chk("no_done", 32'(DONE), 32'd0);
            chk("still_idle", 32'(READY), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
